// File: rtl/sap1_pkg.sv
// sap1_pkg: shared constants for the SAP-1 controller-sequencer.
//   - opcode values for the implemented instructions
//   - one-hot T-state encodings T1..T6
//   - control-word bit positions and the all-inactive control word
//   - helpers that gate load strobes and extract the bus-driver enables
package sap1_pkg;

    localparam int OPCODE_W_DEF = 4;
    localparam int NUM_T        = 6;

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    localparam logic [NUM_T-1:0] T1 = 6'b000001;
    localparam logic [NUM_T-1:0] T2 = 6'b000010;
    localparam logic [NUM_T-1:0] T3 = 6'b000100;
    localparam logic [NUM_T-1:0] T4 = 6'b001000;
    localparam logic [NUM_T-1:0] T5 = 6'b010000;
    localparam logic [NUM_T-1:0] T6 = 6'b100000;

    // Control word layout, MSB first: Cp Ep Lm_n CE_n Li_n Ei_n La_n Ea Su Eu Lb_n Lo_n
    localparam int CW_W    = 12;
    localparam int CW_CP   = 11;
    localparam int CW_EP   = 10;
    localparam int CW_LM_N = 9;
    localparam int CW_CE_N = 8;
    localparam int CW_LI_N = 7;
    localparam int CW_EI_N = 6;
    localparam int CW_LA_N = 5;
    localparam int CW_EA   = 4;
    localparam int CW_SU   = 3;
    localparam int CW_EU   = 2;
    localparam int CW_LB_N = 1;
    localparam int CW_LO_N = 0;

    // Active-low bits at 1, active-high bits at 0.
    localparam logic [CW_W-1:0] CW_INACTIVE = 12'b0011_1110_0011;

    // Bits that act as edge-sampled strobes (register loads and PC increment).
    localparam logic [CW_W-1:0] CW_STROBE_MASK = 12'b1010_1010_0011;

    // Forces the strobe bits inactive unless this cycle carries an advance.
    function automatic logic [CW_W-1:0] cw_gate_strobes(input logic [CW_W-1:0] cw,
                                                        input logic            adv);
        logic [CW_W-1:0] gated;
        gated = adv ? cw : ((cw & ~CW_STROBE_MASK) | (CW_INACTIVE & CW_STROBE_MASK));
        return gated;
    endfunction

    // Bus-driver enables, normalised to active-high.
    function automatic logic [4:0] cw_bus_enables(input logic [CW_W-1:0] cw);
        return {cw[CW_EP], ~cw[CW_CE_N], ~cw[CW_EI_N], cw[CW_EA], cw[CW_EU]};
    endfunction

endpackage

// File: rtl/sap1_ring_counter.sv
// sap1_ring_counter: one-hot T-state ring T1 -> T2 -> ... -> T6 -> T1.
// Ports:
//   clk_i     in   clock, rising edge
//   rst_i     in   synchronous active-high reset, loads T1
//   adv_i     in   advance enable for this cycle
//   freeze_i  in   hold the current state regardless of adv_i
//   tstate_o  out  one-hot current T-state (bit0 = T1)
module sap1_ring_counter
    import sap1_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             adv_i,
    input  logic             freeze_i,
    output logic [NUM_T-1:0] tstate_o
);

    logic [NUM_T-1:0] tstate;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tstate <= T1;
        end else if (adv_i && !freeze_i) begin
            tstate <= {tstate[NUM_T-2:0], tstate[NUM_T-1]};
        end
    end

    assign tstate_o = tstate;

endmodule

// File: rtl/sap1_control_sequencer.sv
// sap1_control_sequencer: SAP-1 controller-sequencer. A 6-state one-hot ring
// (T1-T3 fetch, T4-T6 execute) plus an opcode decoder producing the control
// word that drives the bus enables and every datapath register load. HLT
// freezes the ring at T4 with the control word inactive until reset.
//
// Optional feature macro: SAP1_SEQ_SINGLE_STEP_EN
//   Adds step_i. A rising edge on step_i (registered history) advances the
//   ring by one T-state; load strobes and pc_inc_o fire only in that cycle
//   while bus enables and sub_o are held for the whole T-state.
//
// Ports:
//   clk_i, rst_i       clock and synchronous active-high reset
//   step_i             single-step request (only with SAP1_SEQ_SINGLE_STEP_EN)
//   opcode_i           IR upper nibble, used in T4-T6 only
//   tstate_o           one-hot T-state
//   pc_inc_o, pc_en_o, mar_load_n_o, ram_en_n_o, instr_load_n_o, instr_en_n_o,
//   a_acc_load_n_o, a_acc_en_o, sub_o, add_sub_en_o, b_reg_load_n_o,
//   out_reg_load_n_o   control word (_n = active low)
//   halt_o             machine halted
module sap1_control_sequencer
    import sap1_pkg::*;
#(
    parameter int NUM_TSTATES = 6,
    parameter int OPCODE_W    = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
`ifdef SAP1_SEQ_SINGLE_STEP_EN
    input  logic                step_i,
`endif
    input  logic [OPCODE_W-1:0] opcode_i,
    output logic [5:0]          tstate_o,
    output logic                pc_inc_o,
    output logic                pc_en_o,
    output logic                mar_load_n_o,
    output logic                ram_en_n_o,
    output logic                instr_load_n_o,
    output logic                instr_en_n_o,
    output logic                a_acc_load_n_o,
    output logic                a_acc_en_o,
    output logic                sub_o,
    output logic                add_sub_en_o,
    output logic                b_reg_load_n_o,
    output logic                out_reg_load_n_o,
    output logic                halt_o
);

    generate
        if (NUM_TSTATES != 6) begin : g_bad_tstates
            $error("sap1_control_sequencer: only NUM_TSTATES = 6 is supported");
        end
        if (OPCODE_W != OPCODE_W_DEF) begin : g_bad_opcode_w
            $error("sap1_control_sequencer: only OPCODE_W = 4 is supported");
        end
    endgenerate

    logic [NUM_T-1:0] tstate;
    logic             halted;
    logic             adv;
    logic             hlt_in_t4;
    logic             freeze;
    logic [CW_W-1:0]  cw_raw;
    logic [CW_W-1:0]  cw;

`ifdef SAP1_SEQ_SINGLE_STEP_EN
    logic step_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            step_q <= 1'b0;
        end else begin
            step_q <= step_i;
        end
    end

    assign adv = step_i & ~step_q;
`else
    assign adv = 1'b1;
`endif

    // Freezing already on the T4 edge keeps the ring parked at T4 once HLT executes.
    assign hlt_in_t4 = (tstate == T4) && (opcode_i == OP_HLT);
    assign freeze    = halted | hlt_in_t4;

    sap1_ring_counter u_ring (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .adv_i    (adv),
        .freeze_i (freeze),
        .tstate_o (tstate)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            halted <= 1'b0;
        end else if (hlt_in_t4 && adv) begin
            halted <= 1'b1;
        end
    end

    always_comb begin
        cw_raw = CW_INACTIVE;
        case (tstate)
            T1: begin
                cw_raw[CW_EP]   = 1'b1;
                cw_raw[CW_LM_N] = 1'b0;
            end
            T2: begin
                cw_raw[CW_CP] = 1'b1;
            end
            T3: begin
                cw_raw[CW_CE_N] = 1'b0;
                cw_raw[CW_LI_N] = 1'b0;
            end
            T4: begin
                case (opcode_i)
                    OP_LDA, OP_ADD, OP_SUB: begin
                        cw_raw[CW_EI_N] = 1'b0;
                        cw_raw[CW_LM_N] = 1'b0;
                    end
                    OP_OUT: begin
                        cw_raw[CW_EA]   = 1'b1;
                        cw_raw[CW_LO_N] = 1'b0;
                    end
                    default: ;
                endcase
            end
            T5: begin
                case (opcode_i)
                    OP_LDA: begin
                        cw_raw[CW_CE_N] = 1'b0;
                        cw_raw[CW_LA_N] = 1'b0;
                    end
                    OP_ADD, OP_SUB: begin
                        cw_raw[CW_CE_N] = 1'b0;
                        cw_raw[CW_LB_N] = 1'b0;
                    end
                    default: ;
                endcase
            end
            T6: begin
                case (opcode_i)
                    OP_ADD, OP_SUB: begin
                        cw_raw[CW_EU]   = 1'b1;
                        cw_raw[CW_LA_N] = 1'b0;
                        cw_raw[CW_SU]   = (opcode_i == OP_SUB);
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    assign cw = (rst_i || halted) ? CW_INACTIVE : cw_gate_strobes(cw_raw, adv);

    assign tstate_o         = tstate;
    assign halt_o           = halted;
    assign pc_inc_o         = cw[CW_CP];
    assign pc_en_o          = cw[CW_EP];
    assign mar_load_n_o     = cw[CW_LM_N];
    assign ram_en_n_o       = cw[CW_CE_N];
    assign instr_load_n_o   = cw[CW_LI_N];
    assign instr_en_n_o     = cw[CW_EI_N];
    assign a_acc_load_n_o   = cw[CW_LA_N];
    assign a_acc_en_o       = cw[CW_EA];
    assign sub_o            = cw[CW_SU];
    assign add_sub_en_o     = cw[CW_EU];
    assign b_reg_load_n_o   = cw[CW_LB_N];
    assign out_reg_load_n_o = cw[CW_LO_N];

`ifndef SYNTHESIS
    // Two simultaneous bus drivers would mean contention on the shared W bus.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert ($countones(cw_bus_enables(cw)) <= 1)
                else $error("bus contention: enables=%b tstate=%b opcode=%b",
                            cw_bus_enables(cw), tstate, opcode_i);
        end
    end
`endif

endmodule

// File: tb/tb_sap1_control_sequencer.sv
// Directed bench for sap1_control_sequencer. Expected control words are
// hand-computed 12-bit values in the order
// Cp Ep Lm_n CE_n Li_n Ei_n La_n Ea Su Eu Lb_n Lo_n.
module tb_sap1_control_sequencer;

    localparam logic [11:0] CW_IDLE = 12'h3E3;
    localparam logic [11:0] CW_T1   = 12'h5E3;
    localparam logic [11:0] CW_T2   = 12'hBE3;
    localparam logic [11:0] CW_T3   = 12'h263;
    localparam logic [11:0] CW_MEMA = 12'h1A3;  // Ei_n=0, Lm_n=0
    localparam logic [11:0] CW_LDA5 = 12'h2C3;  // CE_n=0, La_n=0
    localparam logic [11:0] CW_ADD5 = 12'h2E1;  // CE_n=0, Lb_n=0
    localparam logic [11:0] CW_ADD6 = 12'h3C7;  // Eu=1, La_n=0, Su=0
    localparam logic [11:0] CW_SUB6 = 12'h3CF;  // Eu=1, La_n=0, Su=1
    localparam logic [11:0] CW_OUT4 = 12'h3F2;  // Ea=1, Lo_n=0

    logic       clk = 1'b0;
    logic       rst;
    logic       step;
    logic [3:0] opcode;
    logic [5:0] tstate;
    logic       pc_inc, pc_en, mar_load_n, ram_en_n, instr_load_n, instr_en_n;
    logic       a_acc_load_n, a_acc_en, sub, add_sub_en, b_reg_load_n, out_reg_load_n;
    logic       halt;
    logic [11:0] cw_obs;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    sap1_control_sequencer dut (
        .clk_i            (clk),
        .rst_i            (rst),
`ifdef SAP1_SEQ_SINGLE_STEP_EN
        .step_i           (step),
`endif
        .opcode_i         (opcode),
        .tstate_o         (tstate),
        .pc_inc_o         (pc_inc),
        .pc_en_o          (pc_en),
        .mar_load_n_o     (mar_load_n),
        .ram_en_n_o       (ram_en_n),
        .instr_load_n_o   (instr_load_n),
        .instr_en_n_o     (instr_en_n),
        .a_acc_load_n_o   (a_acc_load_n),
        .a_acc_en_o       (a_acc_en),
        .sub_o            (sub),
        .add_sub_en_o     (add_sub_en),
        .b_reg_load_n_o   (b_reg_load_n),
        .out_reg_load_n_o (out_reg_load_n),
        .halt_o           (halt)
    );

    assign cw_obs = {pc_inc, pc_en, mar_load_n, ram_en_n, instr_load_n, instr_en_n,
                     a_acc_load_n, a_acc_en, sub, add_sub_en, b_reg_load_n, out_reg_load_n};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
            else begin
                miscompares++;
                $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
            end
    endtask

    // One T-state advance. In single-step builds this is an idle cycle
    // followed by raising step_i so that the sampled cycle carries the advance.
    task automatic tick();
`ifdef SAP1_SEQ_SINGLE_STEP_EN
        @(posedge clk); #1;
        step = 1'b0;
        @(posedge clk); #1;
        step = 1'b1;
        #1;
`else
        @(posedge clk); #1;
`endif
    endtask

    task automatic run_instr(input logic [3:0] op, input logic [11:0] e4,
                             input logic [11:0] e5, input logic [11:0] e6);
        opcode = op;
        #1;
        check($sformatf("op%h T1 tstate", op), tstate, 6'b000001);
        check($sformatf("op%h T1 cw", op), cw_obs, CW_T1);
        tick();
        check($sformatf("op%h T2 tstate", op), tstate, 6'b000010);
        check($sformatf("op%h T2 cw", op), cw_obs, CW_T2);
        tick();
        check($sformatf("op%h T3 tstate", op), tstate, 6'b000100);
        check($sformatf("op%h T3 cw", op), cw_obs, CW_T3);
        tick();
        check($sformatf("op%h T4 tstate", op), tstate, 6'b001000);
        check($sformatf("op%h T4 cw", op), cw_obs, e4);
        tick();
        check($sformatf("op%h T5 tstate", op), tstate, 6'b010000);
        check($sformatf("op%h T5 cw", op), cw_obs, e5);
        tick();
        check($sformatf("op%h T6 tstate", op), tstate, 6'b100000);
        check($sformatf("op%h T6 cw", op), cw_obs, e6);
        check($sformatf("op%h T6 halt", op), halt, 1'b0);
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] e4, e5, e6;
        int          inc_cycles;

        rst    = 1'b1;
        step   = 1'b0;
        opcode = 4'b0000;

        // Reset
        repeat (2) @(posedge clk);
        #1;
        check("reset tstate", tstate, 6'b000001);
        check("reset halt", halt, 1'b0);
        check("reset cw forced idle", cw_obs, CW_IDLE);
        rst = 1'b0;
`ifdef SAP1_SEQ_SINGLE_STEP_EN
        step = 1'b1;
`endif
        #1;
        check("post-reset tstate", tstate, 6'b000001);
        check("post-reset pc_en", pc_en, 1'b1);
        check("post-reset mar_load_n", mar_load_n, 1'b0);
        check("post-reset halt", halt, 1'b0);

        // LDA, ADD, SUB, OUT
        run_instr(4'b0000, CW_MEMA, CW_LDA5, CW_IDLE);
        run_instr(4'b0001, CW_MEMA, CW_ADD5, CW_ADD6);
        run_instr(4'b0010, CW_MEMA, CW_ADD5, CW_SUB6);
        run_instr(4'b1110, CW_OUT4, CW_IDLE, CW_IDLE);

        // Every non-halting opcode through all six T-states
        for (int op = 0; op < 15; op++) begin
            case (op)
                0:       begin e4 = CW_MEMA; e5 = CW_LDA5; e6 = CW_IDLE; end
                1:       begin e4 = CW_MEMA; e5 = CW_ADD5; e6 = CW_ADD6; end
                2:       begin e4 = CW_MEMA; e5 = CW_ADD5; e6 = CW_SUB6; end
                14:      begin e4 = CW_OUT4; e5 = CW_IDLE; e6 = CW_IDLE; end
                default: begin e4 = CW_IDLE; e5 = CW_IDLE; e6 = CW_IDLE; end
            endcase
            run_instr(op[3:0], e4, e5, e6);
        end

        // HLT
        opcode = 4'b1111;
        #1;
        check("hlt T1 cw", cw_obs, CW_T1);
        tick();
        tick();
        tick();
        check("hlt T4 tstate", tstate, 6'b001000);
        check("hlt T4 cw", cw_obs, CW_IDLE);
        check("hlt T4 halt", halt, 1'b0);
        tick();
        for (int i = 0; i < 20; i++) begin
            check($sformatf("halted[%0d] halt", i), halt, 1'b1);
            check($sformatf("halted[%0d] tstate", i), tstate, 6'b001000);
            check($sformatf("halted[%0d] cw", i), cw_obs, CW_IDLE);
            tick();
        end
        rst = 1'b1;
        #1;
        check("hlt reset cw", cw_obs, CW_IDLE);
        tick();
        check("hlt cleared halt", halt, 1'b0);
        check("hlt cleared tstate", tstate, 6'b000001);
        rst = 1'b0;
        #1;
        check("hlt cleared cw", cw_obs, CW_T1);

        // ADD abandoned by reset in T5
        opcode = 4'b0001;
        tick();
        tick();
        tick();
        tick();
        check("abort T5 tstate", tstate, 6'b010000);
        check("abort T5 b_load before rst", b_reg_load_n, 1'b0);
        rst = 1'b1;
        #1;
        check("abort T5 b_load under rst", b_reg_load_n, 1'b1);
        check("abort T5 cw under rst", cw_obs, CW_IDLE);
        tick();
        rst = 1'b0;
        #1;
        check("abort next tstate", tstate, 6'b000001);
        check("abort next cw", cw_obs, CW_T1);

`ifdef SAP1_SEQ_SINGLE_STEP_EN
        // Three step pulses from T1 land on T4 with a single PC increment
        rst  = 1'b1;
        step = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        inc_cycles = 0;
        for (int i = 0; i < 9; i++) begin
            step = (i % 3 == 0);
            #1;
            if (pc_inc) inc_cycles++;
            @(posedge clk); #1;
        end
        step = 1'b0;
        #1;
        check("step tstate", tstate, 6'b001000);
        check("step pc_inc cycles", inc_cycles, 1);
`else
        inc_cycles = 0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
